// File: rtl/cluster_bus_remap_ctrl.sv
// ---------------------------------------------------------------------------
// cluster_bus_remap_ctrl
//
// Admission and reconfiguration controller for the cluster AXI crossbar
// address map. Watches the AW/AR/B/R handshakes of every crossbar slave port
// and keeps per-port outstanding write and read counts. Ports that reach
// MAX_TXNS outstanding transactions are throttled. A reconfiguration request
// blocks new address beats and waits until nothing is in flight. The new
// cluster ID is then committed in one cycle, so no transaction is ever decoded
// against a map that is changing.
//
// Handshake semantics (all channels): a beat transfers in a cycle where
// valid and ready are both high. Once a gated AX valid has been presented to
// the crossbar without ready (the beat is "pending"), that port is never
// blocked until the beat transfers, so valid never drops before ready.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   aw_valid_i / ar_valid_i        AX valid from upstream masters
//   aw_ready_o / ar_ready_o        gated AX ready back to upstream
//   aw_valid_o / ar_valid_o        gated AX valid to the crossbar
//   aw_ready_i / ar_ready_i        AX ready from the crossbar
//   b_valid_i, b_ready_i           B handshake (monitored only)
//   r_valid_i, r_ready_i, r_last_i R handshake (monitored only)
//   cfg_valid_i, cfg_cluster_id_i  reconfiguration request, held until ack
//   cfg_ready_o                    one-cycle pulse when the new ID commits
//   cluster_id_o                   registered ID for the crossbar decode
//   busy_o                         high while draining or committing
//   err_o                          sticky: response seen with zero count
//   state_o                        debug view of the controller state
// ---------------------------------------------------------------------------
module cluster_bus_remap_ctrl #(
  parameter int              NB_SLAVE       = 4,
  parameter int              MAX_TXNS       = 12,
  parameter int              ID_W           = 6,
  parameter logic [ID_W-1:0] RST_CLUSTER_ID = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NB_SLAVE-1:0] aw_valid_i,
  input  logic [NB_SLAVE-1:0] ar_valid_i,
  output logic [NB_SLAVE-1:0] aw_ready_o,
  output logic [NB_SLAVE-1:0] ar_ready_o,
  output logic [NB_SLAVE-1:0] aw_valid_o,
  output logic [NB_SLAVE-1:0] ar_valid_o,
  input  logic [NB_SLAVE-1:0] aw_ready_i,
  input  logic [NB_SLAVE-1:0] ar_ready_i,
  input  logic [NB_SLAVE-1:0] b_valid_i,
  input  logic [NB_SLAVE-1:0] b_ready_i,
  input  logic [NB_SLAVE-1:0] r_valid_i,
  input  logic [NB_SLAVE-1:0] r_ready_i,
  input  logic [NB_SLAVE-1:0] r_last_i,
  input  logic                cfg_valid_i,
  input  logic [ID_W-1:0]     cfg_cluster_id_i,
  output logic                cfg_ready_o,
  output logic [ID_W-1:0]     cluster_id_o,
  output logic                busy_o,
  output logic                err_o,
  output logic [1:0]          state_o
);

  localparam int               CNT_W   = $clog2(MAX_TXNS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TXNS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    UPDATE = 2'd2
  } state_e;

  state_e              state;
  logic [ID_W-1:0]     pend_id;

  logic [CNT_W-1:0]    wcnt     [NB_SLAVE];
  logic [CNT_W-1:0]    rcnt     [NB_SLAVE];
  logic [CNT_W-1:0]    wcnt_nxt [NB_SLAVE];
  logic [CNT_W-1:0]    rcnt_nxt [NB_SLAVE];

  logic [NB_SLAVE-1:0] aw_pend;
  logic [NB_SLAVE-1:0] ar_pend;
  logic [NB_SLAVE-1:0] blk_aw;
  logic [NB_SLAVE-1:0] blk_ar;
  logic [NB_SLAVE-1:0] aw_hs;
  logic [NB_SLAVE-1:0] ar_hs;
  logic [NB_SLAVE-1:0] b_hs;
  logic [NB_SLAVE-1:0] r_hs;
  logic [NB_SLAVE-1:0] w_under;
  logic [NB_SLAVE-1:0] r_under;
  logic                all_idle;

  // -------------------------------------------------------------------------
  // Address-channel gating. A pending beat overrides every block reason.
  // -------------------------------------------------------------------------
  always_comb begin
    blk_aw = '0;
    blk_ar = '0;
    for (int i = 0; i < NB_SLAVE; i++) begin
      blk_aw[i] = ~aw_pend[i] & ((state != IDLE) | (wcnt[i] == CNT_MAX));
      blk_ar[i] = ~ar_pend[i] & ((state != IDLE) | (rcnt[i] == CNT_MAX));
    end
  end

  assign aw_valid_o = aw_valid_i & ~blk_aw;
  assign aw_ready_o = aw_ready_i & ~blk_aw;
  assign ar_valid_o = ar_valid_i & ~blk_ar;
  assign ar_ready_o = ar_ready_i & ~blk_ar;

  assign aw_hs = aw_valid_o & aw_ready_i;
  assign ar_hs = ar_valid_o & ar_ready_i;
  assign b_hs  = b_valid_i & b_ready_i;
  // Only the last R beat closes a read transaction.
  assign r_hs  = r_valid_i & r_ready_i & r_last_i;

  // -------------------------------------------------------------------------
  // Counter next-state. A simultaneous open and close leaves the count alone;
  // a close against an empty count is flagged and the count stays at zero.
  // -------------------------------------------------------------------------
  always_comb begin
    w_under = '0;
    r_under = '0;
    for (int i = 0; i < NB_SLAVE; i++) begin
      wcnt_nxt[i] = wcnt[i];
      rcnt_nxt[i] = rcnt[i];

      if (aw_hs[i] && !b_hs[i]) begin
        if (wcnt[i] != CNT_MAX) wcnt_nxt[i] = wcnt[i] + CNT_ONE;
      end else if (b_hs[i] && !aw_hs[i]) begin
        if (wcnt[i] == '0) w_under[i] = 1'b1;
        else               wcnt_nxt[i] = wcnt[i] - CNT_ONE;
      end

      if (ar_hs[i] && !r_hs[i]) begin
        if (rcnt[i] != CNT_MAX) rcnt_nxt[i] = rcnt[i] + CNT_ONE;
      end else if (r_hs[i] && !ar_hs[i]) begin
        if (rcnt[i] == '0) r_under[i] = 1'b1;
        else               rcnt_nxt[i] = rcnt[i] - CNT_ONE;
      end
    end
  end

  // Drain completion looks only at registered state, so a beat accepted in
  // the same cycle is still seen as in flight on the following cycle.
  always_comb begin
    all_idle = ~(|aw_pend) & ~(|ar_pend);
    for (int i = 0; i < NB_SLAVE; i++) begin
      all_idle = all_idle & (wcnt[i] == '0) & (rcnt[i] == '0);
    end
  end

  // -------------------------------------------------------------------------
  // Counters, pending flags and sticky error.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB_SLAVE; i++) begin
        wcnt[i] <= '0;
        rcnt[i] <= '0;
      end
      aw_pend <= '0;
      ar_pend <= '0;
      err_o   <= 1'b0;
    end else begin
      for (int i = 0; i < NB_SLAVE; i++) begin
        wcnt[i] <= wcnt_nxt[i];
        rcnt[i] <= rcnt_nxt[i];
        // Set while presented without ready, cleared when the beat moves.
        if (aw_hs[i])         aw_pend[i] <= 1'b0;
        else if (aw_valid_o[i]) aw_pend[i] <= 1'b1;
        if (ar_hs[i])         ar_pend[i] <= 1'b0;
        else if (ar_valid_o[i]) ar_pend[i] <= 1'b1;
      end
      if (|w_under || |r_under) err_o <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Reconfiguration FSM. cfg_ready_o and busy_o are registered alongside the
  // state so they line up exactly with UPDATE and DRAIN/UPDATE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      pend_id      <= RST_CLUSTER_ID;
      cluster_id_o <= RST_CLUSTER_ID;
      cfg_ready_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      cfg_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid_i) begin
            pend_id <= cfg_cluster_id_i;
            state   <= DRAIN;
            busy_o  <= 1'b1;
          end
        end
        DRAIN: begin
          if (all_idle) begin
            state       <= UPDATE;
            cfg_ready_o <= 1'b1;
          end
        end
        UPDATE: begin
          cluster_id_o <= pend_id;
          state        <= IDLE;
          busy_o       <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cluster_bus_remap_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for cluster_bus_remap_ctrl: directed scenarios followed by random
// traffic. A behavioural model (outstanding counts as integers, pending beats
// as flags, a phase variable for the request) predicts the gated outputs each
// cycle; committed IDs are pushed into exp_q and checked by a monitor when
// cfg_ready_o appears.
// ---------------------------------------------------------------------------
module tb_cluster_bus_remap_ctrl;
  localparam int NB   = 4;
  localparam int MAXT = 12;
  localparam int IDW  = 6;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NB-1:0]  aw_valid_i, ar_valid_i, aw_ready_i, ar_ready_i;
  logic [NB-1:0]  b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
  logic [NB-1:0]  aw_ready_o, ar_ready_o, aw_valid_o, ar_valid_o;
  logic           cfg_valid_i;
  logic [IDW-1:0] cfg_cluster_id_i;
  logic           cfg_ready_o;
  logic [IDW-1:0] cluster_id_o;
  logic           busy_o, err_o;
  logic [1:0]     state_o;

  cluster_bus_remap_ctrl #(
    .NB_SLAVE(NB), .MAX_TXNS(MAXT), .ID_W(IDW), .RST_CLUSTER_ID('0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .aw_valid_i(aw_valid_i), .ar_valid_i(ar_valid_i),
    .aw_ready_o(aw_ready_o), .ar_ready_o(ar_ready_o),
    .aw_valid_o(aw_valid_o), .ar_valid_o(ar_valid_o),
    .aw_ready_i(aw_ready_i), .ar_ready_i(ar_ready_i),
    .b_valid_i(b_valid_i), .b_ready_i(b_ready_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
    .cfg_valid_i(cfg_valid_i), .cfg_cluster_id_i(cfg_cluster_id_i),
    .cfg_ready_o(cfg_ready_o), .cluster_id_o(cluster_id_o),
    .busy_o(busy_o), .err_o(err_o), .state_o(state_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [IDW-1:0] exp_q[$];

  // reference model state
  int             wout [NB];
  int             rout [NB];
  bit             awp  [NB];
  bit             arp  [NB];
  int             phase;      // 0 idle, 1 draining, 2 committing
  logic [IDW-1:0] m_pend, m_cid;
  bit             m_err;
  bit             committed;
  logic [NB-1:0]  e_awv, e_awr, e_arv, e_arr, last_aw_hs, last_ar_hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      wout[i] = 0; rout[i] = 0; awp[i] = 0; arp[i] = 0;
    end
    phase = 0; m_pend = '0; m_cid = '0; m_err = 0; committed = 0;
    last_aw_hs = '0; last_ar_hs = '0;
    exp_q.delete();
  endtask

  task automatic clr_in();
    aw_valid_i = '0; ar_valid_i = '0; aw_ready_i = '0; ar_ready_i = '0;
    b_valid_i = '0; b_ready_i = '0; r_valid_i = '0; r_ready_i = '0; r_last_i = '0;
    cfg_valid_i = 1'b0; cfg_cluster_id_i = '0;
  endtask

  // One clock: compare against the model at the falling edge, advance the
  // model with the handshakes it predicts, then return just after the rise.
  task automatic step();
    bit quiet;
    bit bh, rh;
    @(negedge clk);
    quiet = 1;
    for (int i = 0; i < NB; i++) begin
      bit blk_w, blk_r;
      blk_w = !awp[i] && (phase != 0 || wout[i] == MAXT);
      blk_r = !arp[i] && (phase != 0 || rout[i] == MAXT);
      e_awv[i] = aw_valid_i[i] & !blk_w;
      e_awr[i] = aw_ready_i[i] & !blk_w;
      e_arv[i] = ar_valid_i[i] & !blk_r;
      e_arr[i] = ar_ready_i[i] & !blk_r;
      if (wout[i] != 0 || rout[i] != 0 || awp[i] || arp[i]) quiet = 0;
    end
    chk("aw_valid_o", 32'(aw_valid_o), 32'(e_awv));
    chk("aw_ready_o", 32'(aw_ready_o), 32'(e_awr));
    chk("ar_valid_o", 32'(ar_valid_o), 32'(e_arv));
    chk("ar_ready_o", 32'(ar_ready_o), 32'(e_arr));
    chk("busy_o", 32'(busy_o), 32'(phase != 0));
    chk("cfg_ready_o", 32'(cfg_ready_o), 32'(phase == 2));
    chk("cluster_id_o", 32'(cluster_id_o), 32'(m_cid));
    chk("err_o", 32'(err_o), 32'(m_err));

    last_aw_hs = e_awv & aw_ready_i;
    last_ar_hs = e_arv & ar_ready_i;
    for (int i = 0; i < NB; i++) begin
      bh = b_valid_i[i] & b_ready_i[i];
      rh = r_valid_i[i] & r_ready_i[i] & r_last_i[i];
      if (last_aw_hs[i] && !bh) wout[i]++;
      else if (bh && !last_aw_hs[i]) begin
        if (wout[i] == 0) m_err = 1; else wout[i]--;
      end
      if (last_ar_hs[i] && !rh) rout[i]++;
      else if (rh && !last_ar_hs[i]) begin
        if (rout[i] == 0) m_err = 1; else rout[i]--;
      end
      if (last_aw_hs[i]) awp[i] = 0; else if (e_awv[i]) awp[i] = 1;
      if (last_ar_hs[i]) arp[i] = 0; else if (e_arv[i]) arp[i] = 1;
    end
    committed = 0;
    case (phase)
      0: if (cfg_valid_i) begin phase = 1; m_pend = cfg_cluster_id_i; exp_q.push_back(cfg_cluster_id_i); end
      1: if (quiet) phase = 2;
      default: begin phase = 0; m_cid = m_pend; committed = 1; end
    endcase
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // scoreboard monitor: pop the expected ID on each commit pulse, check the
  // map output one cycle later
  logic [IDW-1:0] mon_id;
  bit             mon_chk = 0;
  always @(negedge clk) begin
    if (mon_chk) begin
      chk("commit_id", 32'(cluster_id_o), 32'(mon_id));
      mon_chk = 0;
    end
    if (rst_n && cfg_ready_o) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL cfg_ready_spurious cyc=%0d got=1 want=0", cyc);
      end else begin
        mon_id  = exp_q.pop_front();
        mon_chk = 1;
      end
    end
  end

  task automatic rand_drive();
    for (int i = 0; i < NB; i++) begin
      if (last_aw_hs[i]) aw_valid_i[i] = 1'b0;
      if (!aw_valid_i[i]) aw_valid_i[i] = ($urandom_range(0, 2) == 0);
      if (last_ar_hs[i]) ar_valid_i[i] = 1'b0;
      if (!ar_valid_i[i]) ar_valid_i[i] = ($urandom_range(0, 2) == 0);
      aw_ready_i[i] = ($urandom_range(0, 3) != 0);
      ar_ready_i[i] = ($urandom_range(0, 3) != 0);
      b_valid_i[i]  = (wout[i] > 0) && ($urandom_range(0, 3) == 0);
      b_ready_i[i]  = ($urandom_range(0, 1) == 1);
      r_valid_i[i]  = (rout[i] > 0) && ($urandom_range(0, 2) == 0);
      r_ready_i[i]  = ($urandom_range(0, 1) == 1);
      r_last_i[i]   = ($urandom_range(0, 1) == 1);
    end
    if (cfg_valid_i && committed) cfg_valid_i = 1'b0;
    else if (!cfg_valid_i && $urandom_range(0, 40) == 0) begin
      cfg_valid_i      = 1'b1;
      cfg_cluster_id_i = IDW'($urandom_range(0, 63));
    end
  endtask

  initial begin
    clr_in();
    model_reset();

    // reset values
    #1;
    chk("rst_cluster_id", 32'(cluster_id_o), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // commit with nothing outstanding
    for (int k = 0; k < 10; k++) step();
    cfg_valid_i = 1'b1; cfg_cluster_id_i = 6'd5;
    step();
    chk("t1_busy_t1", 32'(busy_o), 32'd1);
    chk("t1_ready_t1", 32'(cfg_ready_o), 32'd0);
    step();
    chk("t1_ready_t2", 32'(cfg_ready_o), 32'd1);
    chk("t1_id_t2", 32'(cluster_id_o), 32'd0);
    step();
    cfg_valid_i = 1'b0;
    chk("t1_id_t3", 32'(cluster_id_o), 32'd5);
    chk("t1_busy_t3", 32'(busy_o), 32'd0);
    chk("t1_ready_t3", 32'(cfg_ready_o), 32'd0);

    // drain waits for three B responses on port 1
    aw_valid_i[1] = 1'b1; aw_ready_i = '1;
    for (int k = 0; k < 3; k++) step();
    aw_valid_i = '0;
    cfg_valid_i = 1'b1; cfg_cluster_id_i = 6'd2;
    step();
    aw_valid_i = '1;
    for (int k = 1; k <= 10; k++) begin
      b_valid_i[1] = (k == 4 || k == 6 || k == 8);
      b_ready_i[1] = b_valid_i[1];
      #1;
      chk("t2_aw_blocked", 32'(aw_valid_o), 32'd0);
      chk("t2_cfg_ready", 32'(cfg_ready_o), 32'(k == 10));
      step();
    end
    cfg_valid_i = 1'b0; b_valid_i = '0; b_ready_i = '0;
    step();                           // all four ports now accept one AW
    aw_valid_i = '0; b_valid_i = '1; b_ready_i = '1;
    step();
    b_valid_i = '0; b_ready_i = '0; aw_ready_i = '0;

    // pending AW survives the start of a drain
    aw_valid_i[3] = 1'b1;
    step();
    cfg_valid_i = 1'b1; cfg_cluster_id_i = 6'd7;
    step();
    chk("t3_pend_held_a", 32'(aw_valid_o[3]), 32'd1);
    step();
    chk("t3_pend_held_b", 32'(aw_valid_o[3]), 32'd1);
    aw_ready_i[3] = 1'b1;
    step();
    aw_valid_i = '0; aw_ready_i = '0;
    step(); step();
    chk("t3_wait_b", 32'(cfg_ready_o), 32'd0);
    b_valid_i[3] = 1'b1; b_ready_i[3] = 1'b1;
    step();
    b_valid_i = '0; b_ready_i = '0;
    chk("t3_ready_b1", 32'(cfg_ready_o), 32'd0);
    step();
    chk("t3_ready_b2", 32'(cfg_ready_o), 32'd1);
    step();
    cfg_valid_i = 1'b0;
    chk("t3_id", 32'(cluster_id_o), 32'd7);

    // read throttle on port 0
    ar_valid_i[0] = 1'b1; ar_ready_i[0] = 1'b1;
    for (int k = 0; k < MAXT; k++) step();
    chk("t4_throttle_rdy", 32'(ar_ready_o[0]), 32'd0);
    chk("t4_throttle_vld", 32'(ar_valid_o[0]), 32'd0);
    step();
    r_valid_i[0] = 1'b1; r_ready_i[0] = 1'b1; r_last_i[0] = 1'b1;
    #1;
    chk("t4_still_full", 32'(ar_ready_o[0]), 32'd0);
    step();
    r_valid_i = '0; r_ready_i = '0; r_last_i = '0;
    chk("t4_release", 32'(ar_ready_o[0]), 32'd1);
    step();
    ar_valid_i = '0;
    chk("t4_full_again", 32'(ar_ready_o[0]), 32'd0);
    ar_ready_i = '0;
    r_valid_i[0] = 1'b1; r_ready_i[0] = 1'b1; r_last_i[0] = 1'b1;
    for (int k = 0; k < MAXT; k++) step();
    r_valid_i = '0; r_ready_i = '0; r_last_i = '0;

    // simultaneous AW/B on port 2, then underflow
    aw_valid_i[2] = 1'b1; aw_ready_i[2] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    b_valid_i[2] = 1'b1; b_ready_i[2] = 1'b1;
    step();
    aw_valid_i = '0; aw_ready_i = '0;
    for (int k = 0; k < 4; k++) step();
    chk("t5_no_err_yet", 32'(err_o), 32'd0);
    step();
    b_valid_i = '0; b_ready_i = '0;
    chk("t5_err_set", 32'(err_o), 32'd1);
    step(); step();
    chk("t5_err_sticky", 32'(err_o), 32'd1);

    // reset while draining
    aw_valid_i[0] = 1'b1; aw_ready_i[0] = 1'b1;
    step(); step();
    aw_valid_i = '0; aw_ready_i = '0;
    cfg_valid_i = 1'b1; cfg_cluster_id_i = 6'd9;
    step(); step();
    chk("t6_draining", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    clr_in();
    model_reset();
    mon_chk = 0;
    #1;
    chk("t6_rst_id", 32'(cluster_id_o), 32'd0);
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    chk("t6_rst_ready", 32'(cfg_ready_o), 32'd0);
    chk("t6_rst_err", 32'(err_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) step();
    chk("t6_never_commit", 32'(cluster_id_o), 32'd0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      rand_drive();
      step();
    end

    // drain: finish pending beats and the open request, answer everything
    for (int k = 0; k < 150; k++) begin
      for (int i = 0; i < NB; i++) begin
        aw_valid_i[i] = awp[i] && !last_aw_hs[i];
        ar_valid_i[i] = arp[i] && !last_ar_hs[i];
        b_valid_i[i]  = (wout[i] > 0);
        r_valid_i[i]  = (rout[i] > 0);
      end
      aw_ready_i = '1; ar_ready_i = '1;
      b_ready_i = '1; r_ready_i = '1; r_last_i = '1;
      if (committed) cfg_valid_i = 1'b0;
      step();
    end
    clr_in();
    step(); step();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("final_idle", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global bound so the run can never hang
  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
